// File: rtl/prog_loader.sv
// Instruction-RAM loader: receives a length-prefixed, XOR-checksummed byte frame
// and writes its payload word-by-word into the instruction RAM while stalling the core.
module prog_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0,
   parameter int MAX_WORDS = 1024
) (
   input  logic              clockCPU,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_data,
   output logic              mem_wren,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [15:0]       words_written,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERR
   } state_t;

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [16:0]       MAX_LEN = 17'(MAX_WORDS);

   state_t      state, state_next;
   logic        ready_next;
   logic        accept;
   logic        last_word;
   logic [15:0] len;
   logic [15:0] len_full;
   logic [7:0]  chk;
   logic [1:0]  byte_cnt;
   logic [23:0] word_lo;

   // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
   // byte_ready is a flop, so a held byte_valid is never consumed while it is low.
   assign accept    = byte_valid && byte_ready;
   assign len_full  = {byte_in, len[7:0]};
   assign last_word = ({1'b0, words_written} + 17'd1) >= {1'b0, len};
   assign dbg_state = state;

   always_ff @(posedge clockCPU or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, ERR: if (start) state_next = LEN_LO;
         LEN_LO: if (accept) state_next = LEN_HI;
         LEN_HI: begin
            if (accept) begin
               if ({1'b0, len_full} > MAX_LEN) state_next = ERR;
               else if (len_full == 16'd0)     state_next = CHECK;
               else                            state_next = DATA;
            end
         end
         DATA:    if (accept && byte_cnt == 2'd3) state_next = WRITE;
         WRITE:   state_next = last_word ? CHECK : DATA;
         CHECK:   if (accept) state_next = ((chk ^ byte_in) == 8'h00) ? DONE : ERR;
         default: state_next = IDLE;
      endcase
      ready_next = state_next inside {LEN_LO, LEN_HI, DATA, CHECK};
   end

   always_ff @(posedge clockCPU or posedge reset) begin
      if (reset) begin
         byte_ready    <= 1'b0;
         mem_addr      <= '0;
         mem_data      <= '0;
         mem_wren      <= 1'b0;
         cpu_hold      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         words_written <= '0;
         len           <= '0;
         chk           <= '0;
         byte_cnt      <= '0;
         word_lo       <= '0;
      end else begin
         byte_ready <= ready_next;
         mem_wren   <= (state_next == WRITE);
         if (accept) chk <= chk ^ byte_in;

         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  chk           <= '0;
                  byte_cnt      <= '0;
                  words_written <= '0;
                  done          <= 1'b0;
                  error         <= 1'b0;
                  busy          <= 1'b1;
                  cpu_hold      <= 1'b1;
               end
            end
            LEN_LO: if (accept) len[7:0]  <= byte_in;
            LEN_HI: if (accept) len[15:8] <= byte_in;
            DATA: begin
               if (accept) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0: word_lo[7:0]   <= byte_in;
                     2'd1: word_lo[15:8]  <= byte_in;
                     2'd2: word_lo[23:16] <= byte_in;
                     default: begin
                        // Address/data land together with wren so they are stable all of WRITE.
                        mem_data <= {byte_in, word_lo};
                        mem_addr <= BASE + ADDR_W'(words_written);
                     end
                  endcase
               end
            end
            WRITE:   words_written <= words_written + 16'd1;
            default: ;
         endcase

         if (state_next == DONE && state != DONE) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
         end
         // Hold stays asserted on error so the core never runs a corrupt image.
         if (state_next == ERR && state != ERR) begin
            error <= 1'b1;
            busy  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frame-level reference model (expected write list and outcome)
// checked every cycle against two instances, one at base 0 and one at base 1023.
module tb_prog_loader;

   logic        clockCPU = 1'b0;
   logic        reset, start, byte_valid;
   logic [7:0]  byte_in;

   logic        d0_ready, d0_wren, d0_hold, d0_busy, d0_done, d0_error;
   logic [9:0]  d0_addr;
   logic [31:0] d0_data;
   logic [15:0] d0_ww;
   logic [2:0]  d0_state;
   logic        d1_ready, d1_wren, d1_hold, d1_busy, d1_done, d1_error;
   logic [9:0]  d1_addr;
   logic [31:0] d1_data;
   logic [15:0] d1_ww;
   logic [2:0]  d1_state;

   prog_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(1024)) dut0 (
      .clockCPU(clockCPU), .reset(reset), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(d0_ready), .mem_addr(d0_addr),
      .mem_data(d0_data), .mem_wren(d0_wren), .cpu_hold(d0_hold), .busy(d0_busy),
      .done(d0_done), .error(d0_error), .words_written(d0_ww), .dbg_state(d0_state)
   );

   prog_loader #(.ADDR_W(10), .BASE_ADDR(1023), .MAX_WORDS(1024)) dut1 (
      .clockCPU(clockCPU), .reset(reset), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(d1_ready), .mem_addr(d1_addr),
      .mem_data(d1_data), .mem_wren(d1_wren), .cpu_hold(d1_hold), .busy(d1_busy),
      .done(d1_done), .error(d1_error), .words_written(d1_ww), .dbg_state(d1_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clockCPU = ~clockCPU;

   int unsigned cyc = 0;
   always @(posedge clockCPU) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [51:0] exp_q[$];          // {addr_base1023, addr_base0, data}
   logic [7:0]  frame_q[$];
   logic [31:0] obs_data[$];
   logic [9:0]  obs_a0[$];
   logic [9:0]  obs_a1[$];
   logic [9:0]  hold_a0 = '0, hold_a1 = '0;
   logic [31:0] hold_d  = '0;
   logic        prev_wren = 1'b0;
   int unsigned first_acc, last_acc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Per-cycle compare against the model's write list and output-hold rules.
   always @(negedge clockCPU) begin
      logic [51:0] e;
      if (!reset) begin
         check("wren_match", d1_wren, d0_wren);
         if (d0_wren) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr_base0", d0_addr, e[41:32]);
               check("wr_addr_base1023", d1_addr, e[51:42]);
               check("wr_data", d0_data, e[31:0]);
               check("wr_data_base1023", d1_data, e[31:0]);
               hold_a0 = e[41:32];
               hold_a1 = e[51:42];
               hold_d  = e[31:0];
            end
            obs_data.push_back(d0_data);
            obs_a0.push_back(d0_addr);
            obs_a1.push_back(d1_addr);
            check("ready_in_write", d0_ready, 0);
            check("write_one_cycle", prev_wren, 0);
         end else begin
            check("hold_addr", {d1_addr, d0_addr}, {hold_a1, hold_a0});
            check("hold_data", d0_data, hold_d);
         end
         prev_wren = d0_wren;
         check("done_and_error", d0_done & d0_error, 0);
         if (d0_busy) check("busy_holds_cpu", d0_hold, 1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_frame();
      start = 1'b1;
      @(posedge clockCPU); #1;
      start = 1'b0;
      check("start_busy", d0_busy, 1);
      check("start_hold", d0_hold, 1);
      check("start_flags", {d0_done, d0_error}, 0);
      check("start_ww", d0_ww, 0);
      check("start_ready", d0_ready, 1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit got = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clockCPU);
         got = d0_ready;
         @(posedge clockCPU); #1;
      end
      if (!got) check("byte_timeout", 0, 1);
      last_acc = cyc;
      if (gap > 0) begin
         byte_valid = 1'b0;
         byte_in    = 8'($urandom_range(0, 255));
         repeat (gap) @(posedge clockCPU);
         #1;
      end
   endtask

   task automatic run_frame(input int gap);
      logic [15:0] len;
      logic [7:0]  x;
      bit          over;
      int          nb;
      len  = {frame_q[1], frame_q[0]};
      over = (len > 16'd1024);
      x    = 8'h00;
      foreach (frame_q[i]) x ^= frame_q[i];
      if (!over)
         for (int i = 0; i < int'(len); i++)
            exp_q.push_back({10'((1023 + i) % 1024), 10'(i % 1024),
                             frame_q[2+4*i+3], frame_q[2+4*i+2],
                             frame_q[2+4*i+1], frame_q[2+4*i]});
      obs_data.delete(); obs_a0.delete(); obs_a1.delete();
      start_frame();
      nb = over ? 2 : frame_q.size();
      for (int i = 0; i < nb; i++) begin
         send_byte(frame_q[i], gap);
         if (i == 0) first_acc = last_acc;
      end
      if (over) begin
         check("oversize_error_now", d0_error, 1);
         check("oversize_ready", d0_ready, 0);
         check("oversize_hold", d0_hold, 1);
      end
      if (gap == 0 && !over) check("latency", last_acc - first_acc, 5 * int'(len) + 2);
      // Bytes offered after the frame must be ignored.
      byte_valid = 1'b1;
      byte_in    = 8'($urandom_range(0, 255));
      repeat (3) @(posedge clockCPU);
      #1;
      byte_valid = 1'b0;
      for (int k = 0; k < 60 && d0_busy; k++) begin
         @(posedge clockCPU); #1;
      end
      check("end_not_busy", d0_busy, 0);
      check("end_done", d0_done, (!over && x == 8'h00));
      check("end_error", d0_error, (over || x != 8'h00));
      check("end_hold", d0_hold, (over || x != 8'h00));
      check("end_ww", d0_ww, over ? 16'd0 : len);
      check("end_ww_base1023", d1_ww, d0_ww);
      check("end_flags_base1023", {d1_done, d1_error, d1_hold}, {d0_done, d0_error, d0_hold});
      check("end_writes_left", exp_q.size(), 0);
      check("end_ready", d0_ready, 0);
      exp_q.delete();
   endtask

   task automatic load_good(input logic [7:0] last);
      frame_q = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
                  8'h93, 8'h01, 8'hA0, 8'h00, last};
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] len;
      logic [7:0]  x;
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      repeat (3) @(posedge clockCPU);
      #1;
      check("reset_outputs", {d0_ready, d0_wren, d0_hold, d0_busy, d0_done, d0_error},  0);
      check("reset_addr_data_ww", {d0_addr, d0_data, d0_ww, d1_addr}, 0);
      reset = 1'b0;
      @(posedge clockCPU); #1;

      // Good frame, back-to-back: pins the model with literal values.
      load_good(8'h72);
      run_frame(0);
      check("good_n_writes", obs_data.size(), 2);
      check("good_word0", obs_data[0], 32'h00500113);
      check("good_word1", obs_data[1], 32'h00A00193);
      check("good_addrs_base0", {obs_a0[0], obs_a0[1]}, {10'd0, 10'd1});
      check("good_addrs_wrap", {obs_a1[0], obs_a1[1]}, {10'd1023, 10'd0});
      check("good_done_lit", {d0_done, d0_error, d0_hold, d0_ww}, {3'b100, 16'd2});

      // Bad checksum: writes still happen, then error.
      load_good(8'h73);
      run_frame(0);
      check("bad_n_writes", obs_data.size(), 2);
      check("bad_flags_lit", {d0_done, d0_error, d0_hold}, 3'b011);

      // Oversize count 1025.
      frame_q = '{8'h01, 8'h04};
      run_frame(0);
      check("oversize_no_writes", obs_data.size(), 0);

      // Empty frame.
      frame_q = '{8'h00, 8'h00, 8'h00};
      run_frame(0);
      check("empty_lit", {d0_done, d0_error, d0_ww}, {2'b10, 16'd0});
      check("empty_no_writes", obs_data.size(), 0);

      // Good frame with 3-cycle gaps between bytes.
      load_good(8'h72);
      run_frame(3);
      check("gaps_n_writes", obs_data.size(), 2);

      // Largest legal count: every address of both bases, including the wrap.
      len = 16'd1024;
      frame_q = '{8'h00, 8'h04};
      x = 8'h04;
      for (int i = 0; i < 4096; i++) begin
         frame_q.push_back(8'($urandom_range(0, 255)));
         x ^= frame_q[frame_q.size()-1];
      end
      frame_q.push_back(x);
      run_frame(0);
      check("max_n_writes", obs_data.size(), int'(len));

      // Reset mid-frame after 6 bytes.
      load_good(8'h72);
      obs_data.delete();
      start_frame();
      for (int i = 0; i < 6; i++) send_byte(frame_q[i], 0);
      reset = 1'b1;
      #1;
      check("midreset_outputs", {d0_ready, d0_wren, d0_hold, d0_busy, d0_done, d0_error}, 0);
      check("midreset_addr_data_ww", {d0_addr, d0_data, d0_ww, d1_addr}, 0);
      hold_a0 = '0; hold_a1 = '0; hold_d = '0; prev_wren = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clockCPU);
      #1;
      reset = 1'b0;
      repeat (5) @(posedge clockCPU);
      #1;
      byte_valid = 1'b0;
      check("midreset_no_writes", obs_data.size(), 0);
      check("midreset_idle", {d0_busy, d0_ready, d0_ww}, 0);

      // Randomized frames: random length, payload, gaps, oversize and corruption.
      for (int n = 0; n < 14; n++) begin
         if ($urandom_range(0, 7) == 0) len = 16'($urandom_range(1025, 65535));
         else                           len = 16'($urandom_range(0, 6));
         frame_q = '{len[7:0], len[15:8]};
         x = len[7:0] ^ len[15:8];
         if (len <= 16'd1024) begin
            for (int i = 0; i < 4 * int'(len); i++) begin
               frame_q.push_back(8'($urandom_range(0, 255)));
               x ^= frame_q[frame_q.size()-1];
            end
            if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
            frame_q.push_back(x);
         end
         run_frame($urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory interface: receives a program as a byte stream and writes it word-by-word into the instruction RAM's write port (address, data, wren).
- The CPU core only ever reads instruction RAM; this block fills that RAM before execution.
- cpu_hold keeps the core stalled while loading.
- Frame format: 2-byte word count (little-endian), then 4·N payload bytes (little-endian words), then 1 checksum byte. The XOR of all frame bytes, including the checksum, must equal 0x00.

Parameters:
ADDR_W, 10, width of the word address driven to the instruction RAM.
BASE_ADDR, 0, word index written by the first payload word.
MAX_WORDS, 1024, largest legal word count; any larger count is rejected.

Ports:
clockCPU  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high.
start  input  1  one-cycle request to begin receiving a frame.
byte_in  input  8  stream byte.
byte_valid  input  1  byte_in is valid.
byte_ready  output  1  loader accepts byte_in this cycle.
mem_addr  output  ADDR_W  word address to the instruction RAM.
mem_data  output  32  write data to the instruction RAM.
mem_wren  output  1  write-enable pulse to the instruction RAM.
cpu_hold  output  1  stall/hold request to the core.
busy  output  1  frame in progress.
done  output  1  frame loaded and checksum good (sticky).
error  output  1  frame rejected (sticky).
words_written  output  16  count of words written in the current frame.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clockCPU.
- Reset values: all outputs 0; FSM in IDLE; internal checksum, byte counter and word assembler cleared.
- A reset asserted mid-frame aborts immediately; no further writes occur.
- Byte transfer: a byte is accepted at a rising edge when byte_valid && byte_ready. byte_ready is a registered, state-derived output, high only in LEN_LO, LEN_HI, DATA and CHECK.
- Running checksum: chk ^= byte_in on every accepted byte.

FSM transitions:
- IDLE: start=1 → LEN_LO. Clears chk, the byte and word counters, words_written, done and error. Sets cpu_hold=1 and busy=1.
- LEN_LO: accept byte → len[7:0], go to LEN_HI.
- LEN_HI: accept byte → len[15:8]; the count is decided from the full 16-bit value:
  - len > MAX_WORDS → ERR.
  - len == 0 → CHECK.
  - otherwise → DATA.
- DATA: accept 4 bytes, the first into bits [7:0] and the fourth into [31:24]. On the 4th byte → WRITE.
- WRITE: lasts exactly 1 cycle with byte_ready=0.
  - Drives mem_wren=1, mem_data = the assembled word, mem_addr = (BASE_ADDR + word_idx) mod 2^ADDR_W, so the address wraps silently.
  - mem_addr and mem_data are registered and stable through the whole WRITE cycle, so the RAM samples correctly on a clock that differs from clockCPU.
  - After the write, word_idx and words_written increment.
  - Next state: DATA if words_written < len, else CHECK.
- CHECK: accept 1 byte. If chk ^ byte == 0x00 → DONE, else → ERR.
- DONE: done=1, busy=0, cpu_hold=0. start=1 → new frame (IDLE actions).
- ERR: error=1, busy=0, cpu_hold stays 1 (the core never runs a corrupt image). start=1 → new frame.

Output hold and ignored input:
- mem_wren is 0 in every state other than WRITE.
- mem_addr and mem_data keep their last values outside WRITE.
- start is ignored while busy=1.
- byte_valid while byte_ready=0 is ignored; the byte is not consumed.

Timing:
- Minimum latency for an N-word frame: 2 + 4N + N + 1 cycles, counted from the first byte to done.
- Stalled bytes (byte_valid=0) only extend that latency; the result is unchanged.

Test Plan:
- Good frame: start; bytes 02 00 13 01 50 00 93 01 A0 00 72 sent back-to-back → exactly 2 mem_wren pulses, addr 0 data 0x00500113 and addr 1 data 0x00A00193; then done=1, error=0, words_written=2, cpu_hold=0.
- Bad checksum: same frame with the last byte 0x73 → both writes still occur; then error=1, done=0, cpu_hold=1.
- Oversize count: bytes 01 04 (1025) → error=1 immediately after the 2nd byte; no mem_wren; byte_ready=0.
- Empty frame: bytes 00 00 00 → done=1, words_written=0, no mem_wren.
- Gaps and stalls: good frame with byte_valid low for 3 cycles between every byte, and byte_valid held high during WRITE → identical writes, no byte lost or duplicated, byte_ready=0 in WRITE cycles.
- Reset and wrap: reset asserted after 6 bytes → all outputs 0 the same cycle, no further writes; BASE_ADDR=1023 with a 2-word frame → writes land at addresses 1023 then 0.
